// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state type, cause indices and widths for the core reset sequencer
package reset_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      SETTLE = 2'd2
   } seq_state_e;

   localparam int CAUSE_CMD  = 0;
   localparam int CAUSE_SVC  = 1;
   localparam int CAUSE_EXT  = 2;
   localparam int CAUSE_HOST = 3;

   localparam int RESET_COUNT_W = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// rtl/reset_seq_timer.sv - loadable down-counter with zero flag, shared by hold and settle phases
module reset_seq_timer #(
   parameter int           W    = 13,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   // Load wins over counting; the counter parks at zero until reloaded.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= INIT;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/core_reset_sequencer.sv
// rtl/core_reset_sequencer.sv - merges reset requests into one held-then-settled core reset sequence
// Define RESET_SEQ_STATS_EN to add the saturating reset_count statistics register.
module core_reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int HOLD_CYCLES   = 8000,
   parameter int SETTLE_CYCLES = 256,
   parameter int NUM_REQ       = 4
) (
   input  logic                     clk_74a,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req,
   output logic                     core_reset_n,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_REQ-1:0]       last_cause,
   output logic [RESET_COUNT_W-1:0] reset_count
);

   localparam int            MAX_CYCLES  = max_int(HOLD_CYCLES, SETTLE_CYCLES);
   localparam int            TW          = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

   seq_state_e         state_q, state_d;
   logic               core_reset_n_q, core_reset_n_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [NUM_REQ-1:0] last_cause_q, last_cause_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [NUM_REQ-1:0] settle_cause;
   logic               tmr_load;
   logic [TW-1:0]      tmr_val;
   logic               tmr_zero;

   reset_seq_timer #(
      .W    (TW),
      .INIT (HOLD_LOAD)
   ) u_timer (
      .clk      (clk_74a),
      .rst_n    (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      last_cause_d = last_cause_q;
      pending_d    = pending_q;
      done_d       = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = HOLD_LOAD;
      settle_cause = pending_q | req;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d      = ASSERT;
               tmr_load     = 1'b1;
               last_cause_d = req;
            end
         end
         ASSERT: begin
            if (|req) begin
               tmr_load     = 1'b1;
               last_cause_d = last_cause_q | req;
            end else if (tmr_zero) begin
               state_d  = SETTLE;
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            // A request on the expiry cycle itself still chains straight into a new hold.
            if (!tmr_zero) begin
               pending_d = settle_cause;
            end else if (|settle_cause) begin
               state_d      = ASSERT;
               tmr_load     = 1'b1;
               last_cause_d = settle_cause;
               pending_d    = '0;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      core_reset_n_d = (state_d != ASSERT);
      busy_d         = (state_d != IDLE);
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ASSERT;
         core_reset_n_q <= 1'b0;
         busy_q         <= 1'b1;
         done_q         <= 1'b0;
         last_cause_q   <= '0;
         pending_q      <= '0;
      end else begin
         state_q        <= state_d;
         core_reset_n_q <= core_reset_n_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         last_cause_q   <= last_cause_d;
         pending_q      <= pending_d;
      end
   end

`ifdef RESET_SEQ_STATS_EN
   logic [RESET_COUNT_W-1:0] reset_count_q, reset_count_d;

   always_comb begin
      reset_count_d = reset_count_q;
      if (state_q == ASSERT && state_d == SETTLE && reset_count_q != '1) begin
         reset_count_d = reset_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         reset_count_q <= '0;
      end else begin
         reset_count_q <= reset_count_d;
      end
   end

   assign reset_count = reset_count_q;
`else
   assign reset_count = '0;
`endif

   assign core_reset_n = core_reset_n_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign last_cause   = last_cause_q;

endmodule

// File: tb/tb_core_reset_sequencer.sv
// tb/tb_core_reset_sequencer.sv - scoreboard bench: stimulus predicts reset edges, monitor checks them
module tb_core_reset_sequencer;
   import reset_seq_pkg::*;

   localparam int HOLD   = 8000;
   localparam int SETTLE = 256;
   localparam int NREQ   = 4;
   localparam int EV_FALL = 0;
   localparam int EV_RISE = 1;
   localparam int EV_DONE = 2;
`ifdef RESET_SEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      int        kind;
      int        cyc;
      logic [3:0] cause;
      int        cnt;
   } ev_t;

   logic            clk_74a;
   logic            reset_n;
   logic [NREQ-1:0] req;
   logic            core_reset_n;
   logic            busy;
   logic            done;
   logic [NREQ-1:0] last_cause;
   logic [7:0]      reset_count;

   ev_t exp_q[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cnt = 0;
   logic prev_crn = 1'b0;
   logic prev_busy = 1'b1;

   core_reset_sequencer #(
      .HOLD_CYCLES   (HOLD),
      .SETTLE_CYCLES (SETTLE),
      .NUM_REQ       (NREQ)
   ) dut (
      .clk_74a      (clk_74a),
      .reset_n      (reset_n),
      .req          (req),
      .core_reset_n (core_reset_n),
      .busy         (busy),
      .done         (done),
      .last_cause   (last_cause),
      .reset_count  (reset_count)
   );

   initial begin
      clk_74a = 1'b0;
      forever #5 clk_74a = ~clk_74a;
   end

   always @(posedge clk_74a) cyc <= cyc + 1;

   function automatic int ec(input int n);
      return STATS ? ((n > 255) ? 255 : n) : 0;
   endfunction

   function automatic logic [3:0] cbit(input int i);
      logic [3:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic string ev_name(input int k);
      return (k == EV_FALL) ? "fall" : (k == EV_RISE) ? "rise" : "done";
   endfunction

   task automatic push(input int k, input int c, input logic [3:0] cause, input int n);
      ev_t e;
      e.kind  = k;
      e.cyc   = c;
      e.cause = cause;
      e.cnt   = ec(n);
      exp_q.push_back(e);
   endtask

   // Monitor: every observed output event is matched against the front of the queue.
   task automatic got(input int k);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_%s: got event at cycle %0d, required no event", ev_name(k), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.cause != last_cause || e.cnt != int'(reset_count)) begin
            n_bad++;
            $display("FAIL event_%s: got %s cyc=%0d cause=%b count=%0d, required %s cyc=%0d cause=%b count=%0d",
                     ev_name(e.kind), ev_name(k), cyc, last_cause, reset_count,
                     ev_name(e.kind), e.cyc, e.cause, e.cnt);
         end
      end
   endtask

   always @(negedge clk_74a) begin
      if (prev_crn && !core_reset_n) got(EV_FALL);
      if (!prev_crn && core_reset_n) got(EV_RISE);
      if (done) got(EV_DONE);
      if (done || (prev_busy && !busy)) begin
         n_cmp++;
         if (!(done && prev_busy && !busy)) begin
            n_bad++;
            $display("FAIL done_vs_busy: got done=%b busy %b->%b at cycle %0d, required done with busy 1->0",
                     done, prev_busy, busy, cyc);
         end
      end
      prev_crn  = core_reset_n;
      prev_busy = busy;
   end

   // Drive v so that it is sampled on edges n .. n+m-1.
   task automatic drive_at(input int n, input logic [3:0] v, input int m);
      while (cyc < n - 1) begin
         @(posedge clk_74a);
         #1;
      end
      req = v;
      repeat (m) begin
         @(posedge clk_74a);
         #1;
      end
      req = '0;
   endtask

   task automatic drain(input string tag, input int budget);
      int b;
      b = budget;
      while (exp_q.size() != 0 && b > 0) begin
         @(posedge clk_74a);
         #1;
         b--;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_%s: got %0d events still outstanding, required 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Sequence from IDLE: first request held for 'held' edges, up to two later extensions.
   task automatic seq_idle(input string tag, input logic [3:0] c0, input int held,
                           input int off1, input logic [3:0] c1, input int off2, input logic [3:0] c2);
      int t, l;
      logic [3:0] cause;
      t = cyc + int'($urandom_range(1, 20));
      l = t + held - 1;
      cause = c0;
      push(EV_FALL, t, c0, cnt);
      if (off1 > 0) begin l = l + off1; cause = cause | c1; end
      if (off2 > 0) begin l = l + off2; cause = cause | c2; end
      cnt++;
      push(EV_RISE, l + HOLD, cause, cnt);
      push(EV_DONE, l + HOLD + SETTLE, cause, cnt);
      drive_at(t, c0, held);
      if (off1 > 0) drive_at(t + held - 1 + off1, c1, 1);
      if (off2 > 0) drive_at(t + held - 1 + off1 + off2, c2, 1);
      drain(tag, 3 * HOLD);
   endtask

   initial begin
      int t, r, s1, s2, h, p;
      logic [3:0] c1, c2;
      reset_n = 1'b0;
      req     = '0;
      repeat (3) @(posedge clk_74a);
      #1;
      n_cmp++;
      if ({core_reset_n, busy, done, last_cause, reset_count} !== {1'b0, 1'b1, 1'b0, 4'b0000, 8'd0}) begin
         n_bad++;
         $display("FAIL reset_state: got crn=%b busy=%b done=%b cause=%b count=%0d, required 0 1 0 0000 0",
                  core_reset_n, busy, done, last_cause, reset_count);
      end

      // Power-up sequence with cause 0.
      reset_n = 1'b1;
      p = cyc;
      cnt = 1;
      push(EV_RISE, p + HOLD, 4'b0000, cnt);
      push(EV_DONE, p + HOLD + SETTLE, 4'b0000, cnt);
      drain("powerup", 3 * HOLD);

      seq_idle("idle_pulse", cbit(CAUSE_CMD), 1, 0, 4'b0000, 0, 4'b0000);
      seq_idle("extend_5000", cbit(CAUSE_CMD), 1, 5000, cbit(CAUSE_EXT), 0, 4'b0000);
      c1 = 4'($urandom_range(1, 15));
      c2 = 4'($urandom_range(1, 15));
      seq_idle("level_extend", c1, int'($urandom_range(2, 40)), int'($urandom_range(1, 1500)), c2,
               int'($urandom_range(1, 500)), cbit(CAUSE_HOST));

      // Request on the very cycle the settle timer expires chains into a new hold.
      c1 = 4'($urandom_range(1, 15));
      t = cyc + int'($urandom_range(1, 20));
      r = t + HOLD;
      push(EV_FALL, t, c1, cnt);
      cnt++;
      push(EV_RISE, r, c1, cnt);
      push(EV_FALL, r + SETTLE, cbit(CAUSE_SVC), cnt);
      cnt++;
      push(EV_RISE, r + SETTLE + HOLD, cbit(CAUSE_SVC), cnt);
      push(EV_DONE, r + SETTLE + HOLD + SETTLE, cbit(CAUSE_SVC), cnt);
      drive_at(t, c1, 1);
      drive_at(r + SETTLE, cbit(CAUSE_SVC), 1);
      drain("settle_chain", 4 * HOLD);

      // Async reset mid-settle with a request pending.
      c1 = 4'($urandom_range(1, 15));
      c2 = 4'($urandom_range(1, 15));
      s1 = int'($urandom_range(1, SETTLE - 2));
      s2 = int'($urandom_range(s1, SETTLE - 1));
      h  = int'($urandom_range(1, 5));
      t = cyc + int'($urandom_range(1, 20));
      r = t + HOLD;
      push(EV_FALL, t, c1, cnt);
      cnt++;
      push(EV_RISE, r, c1, cnt);
      push(EV_FALL, r + s2, 4'b0000, 0);
      drive_at(t, c1, 1);
      drive_at(r + s1, c2, 1);
      while (cyc < r + s2) begin
         @(posedge clk_74a);
         #1;
      end
      reset_n = 1'b0;
      repeat (h) @(posedge clk_74a);
      #1;
      reset_n = 1'b1;
      p = cyc;
      cnt = 1;
      push(EV_RISE, p + HOLD, 4'b0000, cnt);
      push(EV_DONE, p + HOLD + SETTLE, 4'b0000, cnt);
      drain("reset_mid_settle", 3 * HOLD);

      repeat (5) @(posedge clk_74a);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/core_reset_sequencer.md
# core_reset_sequencer

Central core-reset controller on the APF bridge clock domain. It merges reset requests from several sources into one sequenced core reset: bridge reset command, service-mode write, extra-DIP write and the host. Each sequence holds reset for a fixed time, then enforces a settle window. Requests arriving mid-sequence are extended or queued and never dropped. Its outputs feed the per-domain synchronisers and the bridge read-back for the reset status address.

## Interface
- HOLD_CYCLES, 8000: clocks `core_reset_n` is held low per sequence; must be ≥1.
- SETTLE_CYCLES, 256: clocks after release before a new sequence may start; must be ≥1.
- NUM_REQ, 4: number of request inputs; 1..8.
- clk_74a  in  1  bridge clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset of all state.
- req  in  NUM_REQ  single-cycle request pulses, one per source. A level held high counts as a request on every cycle.
- core_reset_n  out  1  registered core reset, active low.
- busy  out  1  high in ASSERT or SETTLE.
- done  out  1  one-cycle pulse on the SETTLE→IDLE transition.
- last_cause  out  NUM_REQ  OR of all request bits that contributed to the most recent sequence.
- reset_count  out  8  number of completed sequences, saturating at 255. Present only with the statistics feature.

## Operation
- States: IDLE, ASSERT, SETTLE.
- Async reset: state=ASSERT, timer=HOLD_CYCLES−1, `core_reset_n`=0, `busy`=1, `done`=0, `last_cause`=0, pending=0, `reset_count`=0. Every power-up therefore runs one full sequence with cause 0.
- IDLE, any `req` bit high:
  - go to ASSERT.
  - load timer to HOLD_CYCLES−1.
  - `last_cause` ← `req` (replaces the previous cause).
- ASSERT, any `req` bit high:
  - reload timer to HOLD_CYCLES−1; this extends the hold.
  - `last_cause` |= `req`.
- ASSERT, timer==0 with no request that cycle: go to SETTLE and load timer to SETTLE_CYCLES−1.
- SETTLE, any `req` bit high: pending |= `req`. Timer is not affected.
- SETTLE, timer==0:
  - pending≠0 (including a request in this same cycle): go to ASSERT, `last_cause` ← pending|`req`, clear pending, load HOLD timer.
  - otherwise: go to IDLE and assert `done`.
- Timer: single down-counter of width $clog2(max(HOLD_CYCLES,SETTLE_CYCLES)), loadable, stops at 0.
- `reset_count` increments on every ASSERT→SETTLE transition, including the power-up sequence, and saturates at 255.

## Timing
- All outputs are registered. No combinational path from `req` to any output.
- Request seen on edge N in IDLE → `core_reset_n` low from edge N+1.
- `core_reset_n` is low for exactly HOLD_CYCLES clocks after the last request seen in ASSERT.
- After release, `busy` stays high for exactly SETTLE_CYCLES clocks.
- `done` is high for one clock, coincident with `busy` falling.
- Back-to-back sequences: the clock after SETTLE timer==0 with pending set, `core_reset_n` goes low again. There is no IDLE cycle between them.
- Async reset mid-sequence: restarts at ASSERT with a full hold. `last_cause` and pending are cleared.

## Configuration
- RESET_SEQ_STATS_EN defined: the 8-bit saturating `reset_count` register is present.
- Not defined: `reset_count` is driven constant 0, and no counter flops are synthesised.
- The sequencing behaviour is identical in both cases.

## Structure
- Package `reset_seq_pkg`:
  - state enum (IDLE, ASSERT, SETTLE);
  - cause bit index constants: CAUSE_CMD=0, CAUSE_SVC=1, CAUSE_EXT=2, CAUSE_HOST=3;
  - `reset_count` width constant.
- Sub-module `reset_seq_timer`: loadable down-counter with load value, load strobe and zero flag. It is shared by the hold and settle phases.
- The FSM, cause and pending registers, and the statistics counter stay in the top module.

## Test plan
- Release `reset_n` → `core_reset_n` low for 8000 clocks, then high. `busy` falls 256 clocks later with a one-cycle `done`. `last_cause`=0 and `reset_count`=1.
- IDLE, `req`=4'b0001 pulse → `core_reset_n` low on the next edge for 8000 clocks. `last_cause`=4'b0001 and `reset_count`=2.
- ASSERT, `req`=4'b0100 pulse 5000 clocks into the hold → low time totals 13000 clocks. `last_cause`=4'b0101.
- SETTLE, `req`=4'b0010 pulse → after settle expires, `core_reset_n` goes low the next clock with no `done`. `last_cause`=4'b0010.
- `req` high during ASSERT, then released → hold ends exactly HOLD_CYCLES clocks after the last high cycle.
- Assert `reset_n` low mid-SETTLE with pending set → pending and `last_cause` cleared. A full 8000-clock hold follows release. With RESET_SEQ_STATS_EN off, `reset_count` stays 0 throughout.
